// File: rtl/bus_to_sample_if.sv
// bus_to_sample_if
//   Word intake channel for bus_to_sample.
//
//   Handshake: a word moves on a rising clock edge where in_valid and in_ready
//   are both high. The source raises in_valid together with in_data. It holds
//   both steady until that edge, and it may not withdraw a word it has offered.
//   The sink raises in_ready whenever it can take a word. in_ready does not
//   depend on in_valid.
//
//   Signals
//     in_data  [63:0]  word to unpack (source -> sink)
//     in_valid         in_data is valid (source -> sink)
//     in_ready         sink can accept a word (sink -> source)
//
//   Modports
//     master : the word source
//     slave  : bus_to_sample
interface bus_to_sample_if;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/bus_to_sample.sv
// bus_to_sample
//   Unpacks one 64-bit word into 8 successive byte samples. Byte k is
//   in_data[8k+7:8k]. Byte 0 goes out first. bitN carries bit N of the
//   current byte. Each sample lasts SAMPLE_DIV fastclk cycles, and the
//   timing comes from a clock-enable counter rather than a derived clock.
//
//   Parameters
//     SAMPLE_DIV  fastclk cycles per sample (>= 2), default 50 MHz / 3334
//     CNT_W       divider width, 2**CNT_W >= SAMPLE_DIV
//
//   Ports
//     fastclk        sole clock
//     reset          synchronous, active-high, dominant
//     in_if          word intake (valid/ready, slave side)
//     bit0..bit7     current sample byte (registered)
//     sample_strobe  one-cycle pulse when a new byte appears on bit0..bit7
//     busy           serialization in progress
//     done           one-cycle pulse as the 8th sample period ends
//     state_dbg      0 = IDLE, 1 = SHIFT
module bus_to_sample #(
  parameter int SAMPLE_DIV = 3334,
  parameter int CNT_W      = 12
) (
  input  logic              fastclk,
  input  logic              reset,
  bus_to_sample_if.slave    in_if,
  output logic              bit0,
  output logic              bit1,
  output logic              bit2,
  output logic              bit3,
  output logic              bit4,
  output logic              bit5,
  output logic              bit6,
  output logic              bit7,
  output logic              sample_strobe,
  output logic              busy,
  output logic              done,
  output logic              state_dbg
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  state_t            state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [2:0]        idx_q,    idx_d;
  logic [63:0]       hold_q,   hold_d;
  logic [7:0]        bits_q,   bits_d;
  logic              strobe_q, strobe_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  logic [2:0]        idx_next;

  assign idx_next = idx_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    bits_d   = bits_q;
    busy_d   = busy_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // in_ready is high throughout IDLE, so valid alone means accept.
        if (in_if.in_valid) begin
          hold_d   = in_if.in_data;
          idx_d    = 3'd0;
          bits_d   = in_if.in_data[7:0];
          strobe_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q != 3'd7) begin
            idx_d    = idx_next;
            bits_d   = hold_q[{idx_next, 3'b000} +: 8];
            strobe_d = 1'b1;
          end else begin
            // The last byte stays on the bits until the next accept.
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge fastclk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      hold_q   <= 64'd0;
      bits_q   <= 8'd0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      bits_q   <= bits_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign in_if.in_ready = (state_q == S_IDLE);

  assign bit0          = bits_q[0];
  assign bit1          = bits_q[1];
  assign bit2          = bits_q[2];
  assign bit3          = bits_q[3];
  assign bit4          = bits_q[4];
  assign bit5          = bits_q[5];
  assign bit6          = bits_q[6];
  assign bit7          = bits_q[7];
  assign sample_strobe = strobe_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_bus_to_sample.sv
// Bench for bus_to_sample. It instantiates two copies of the design:
//   dut_a with SAMPLE_DIV = 4
//   dut_b with the default SAMPLE_DIV = 3334
// The reference model tracks, for each copy, only the cycle offset since the
// last accepted word. It derives every output from that offset.
module tb_bus_to_sample;

  localparam int DIV_A = 4;
  localparam int DIV_B = 3334;

  // ---------------------------------------------------------------- clock/reset
  logic fastclk = 1'b0;
  always #10 fastclk = ~fastclk;

  logic rst_a, rst_b;
  int   cyc = 0;
  bit   chk_en = 1'b0;

  bus_to_sample_if if_a ();
  bus_to_sample_if if_b ();

  logic [7:0] bits_a, bits_b;
  logic strobe_a, busy_a, done_a, st_a;
  logic strobe_b, busy_b, done_b, st_b;

  bus_to_sample #(.SAMPLE_DIV(DIV_A), .CNT_W(3)) dut_a (
    .fastclk(fastclk), .reset(rst_a), .in_if(if_a),
    .bit0(bits_a[0]), .bit1(bits_a[1]), .bit2(bits_a[2]), .bit3(bits_a[3]),
    .bit4(bits_a[4]), .bit5(bits_a[5]), .bit6(bits_a[6]), .bit7(bits_a[7]),
    .sample_strobe(strobe_a), .busy(busy_a), .done(done_a), .state_dbg(st_a)
  );

  bus_to_sample dut_b (
    .fastclk(fastclk), .reset(rst_b), .in_if(if_b),
    .bit0(bits_b[0]), .bit1(bits_b[1]), .bit2(bits_b[2]), .bit3(bits_b[3]),
    .bit4(bits_b[4]), .bit5(bits_b[5]), .bit6(bits_b[6]), .bit7(bits_b[7]),
    .sample_strobe(strobe_b), .busy(busy_b), .done(done_b), .state_dbg(st_b)
  );

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // has = a word has been accepted since reset.
  // d   = number of edges since the accept edge.
  bit          m_has [2];
  int          m_d   [2];
  logic [63:0] m_word[2];

  logic [1:0]  rs, vl;
  logic [63:0] dt [2];
  assign rs    = {rst_b, rst_a};
  assign vl    = {if_b.in_valid, if_a.in_valid};
  assign dt[0] = if_a.in_data;
  assign dt[1] = if_b.in_data;

  function automatic int div_of(input int i);
    return (i == 0) ? DIV_A : DIV_B;
  endfunction

  function automatic bit m_ready(input bit has, input int d, input int dv);
    return !has || (d >= 8 * dv);
  endfunction

  function automatic logic [7:0] m_bits(input bit has, input int d, input logic [63:0] w, input int dv);
    int k;
    if (!has) return 8'h00;
    k = d / dv;
    if (k > 7) k = 7;
    return w[8*k +: 8];
  endfunction

  always @(posedge fastclk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rs[i]) begin
        m_has[i] <= 1'b0;
        m_d[i]   <= 0;
      end else if (vl[i] && m_ready(m_has[i], m_d[i], div_of(i))) begin
        m_has[i]  <= 1'b1;
        m_d[i]    <= 0;
        m_word[i] <= dt[i];
      end else if (m_has[i] && m_d[i] < 9 * div_of(i)) begin
        m_d[i] <= m_d[i] + 1;
      end
    end
  end

  task automatic cmp_dut(input int i, input logic [7:0] bits, input logic stb,
                         input logic bsy, input logic dn, input logic rdy, input logic st);
    int  dv;
    bit  has;
    int  d;
    bit  e_busy;
    dv     = div_of(i);
    has    = m_has[i];
    d      = m_d[i];
    e_busy = has && (d < 8 * dv);
    chk($sformatf("d%0d_bits", i),   bits, m_bits(has, d, m_word[i], dv));
    chk($sformatf("d%0d_strobe", i), stb,  e_busy && (d % dv == 0));
    chk($sformatf("d%0d_busy", i),   bsy,  e_busy);
    chk($sformatf("d%0d_done", i),   dn,   has && (d == 8 * dv));
    chk($sformatf("d%0d_ready", i),  rdy,  m_ready(has, d, dv));
    chk($sformatf("d%0d_state", i),  st,   e_busy);
  endtask

  // Monitor records: strobe cycles, the byte shown at each strobe, done cycles.
  int         str_a[$], str_b[$], done_qa[$], done_qb[$];
  logic [7:0] byt_a[$], byt_b[$];
  int         busy_a_cnt = 0;

  always @(negedge fastclk) begin
    if (chk_en) begin
      cmp_dut(0, bits_a, strobe_a, busy_a, done_a, if_a.in_ready, st_a);
      cmp_dut(1, bits_b, strobe_b, busy_b, done_b, if_b.in_ready, st_b);
      if (strobe_a) begin str_a.push_back(cyc); byt_a.push_back(bits_a); end
      if (strobe_b) begin str_b.push_back(cyc); byt_b.push_back(bits_b); end
      if (done_a) done_qa.push_back(cyc);
      if (done_b) done_qb.push_back(cyc);
      if (busy_a) busy_a_cnt++;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick(input int n);
    repeat (n) @(negedge fastclk);
  endtask

  task automatic set_in(input int i, input logic v, input logic [63:0] w);
    if (i == 0) begin if_a.in_valid = v; if_a.in_data = w; end
    else        begin if_b.in_valid = v; if_b.in_data = w; end
  endtask

  task automatic clear_a();
    str_a.delete(); byt_a.delete(); done_qa.delete(); busy_a_cnt = 0;
  endtask

  // Offers w and waits for the accept edge. Returns e0, the cycle stamp at the
  // negedge just after the accept edge. That negedge is where byte 0 is first
  // visible. keep=1 leaves in_valid high afterwards.
  task automatic send(input int i, input logic [63:0] w, input bit keep, output int e0);
    int n;
    n = 0;
    e0 = -1;
    set_in(i, 1'b1, w);
    while (!((i == 0) ? (if_a.in_ready && !rst_a) : (if_b.in_ready && !rst_b)) && n < 40000) begin
      tick(1);
      n++;
    end
    if (n >= 40000) begin
      failures++;
      checks++;
      $display("FAIL send_timeout dut%0d: got=no_accept expected=accept", i);
      set_in(i, 1'b0, w);
    end else begin
      tick(1);
      e0 = cyc;
      if (!keep) set_in(i, 1'b0, w);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [63:0] exp_q[$];

  // ---------------------------------------------------------------- stimulus
  initial begin
    int          e0, e1;
    logic [63:0] wa, wb, w, rebuilt;

    rst_a = 1'b1; rst_b = 1'b1;
    set_in(0, 1'b0, 64'd0);
    set_in(1, 1'b0, 64'd0);
    tick(3);
    chk_en = 1'b1;
    chk("reset_bits",  bits_a, 8'h00);
    chk("reset_ready", if_a.in_ready, 1'b1);
    chk("reset_busy",  busy_a, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick(2);

    // 1: one word, SAMPLE_DIV = 4.
    clear_a();
    send(0, 64'h8877665544332211, 1'b0, e0);
    tick(40);
    chk("s1_nstrobe", str_a.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < str_a.size()) begin
        chk("s1_strobe_ofs", str_a[k] - e0, 4 * k);
        chk("s1_byte", byt_a[k], 8'h11 * (k + 1));
      end
    end
    chk("s1_busy_cycles", busy_a_cnt, 32);
    chk("s1_ndone", done_qa.size(), 1);
    if (done_qa.size() > 0) chk("s1_done_ofs", done_qa[0] - e0, 32);
    chk("s1_hold", bits_a, 8'h88);

    // 2: back-to-back. in_data is scrambled during SHIFT, then word B waits.
    clear_a();
    wa = {$urandom, $urandom};
    wb = {$urandom, $urandom};
    send(0, wa, 1'b1, e0);
    for (int j = 0; j < 30; j++) begin
      tick(1);
      if_a.in_data = {$urandom, $urandom};
    end
    send(0, wb, 1'b0, e1);
    tick(40);
    chk("s2_accept_gap", e1 - e0, 33);
    chk("s2_nstrobe", str_a.size(), 16);
    if (str_a.size() >= 9) chk("s2_b0_after_a7", str_a[8] - str_a[7], 5);
    for (int k = 0; k < 8; k++) begin
      if (k + 8 < byt_a.size()) begin
        chk("s2_a_byte", byt_a[k], wa[8*k +: 8]);
        chk("s2_b_byte", byt_a[k+8], wb[8*k +: 8]);
      end
    end

    // 3: reset during byte 3.
    clear_a();
    w = {$urandom, $urandom};
    send(0, w, 1'b0, e0);
    tick(13);
    rst_a = 1'b1;
    tick(1);
    rst_a = 1'b0;
    chk("s3_bits", bits_a, 8'h00);
    chk("s3_busy", busy_a, 1'b0);
    chk("s3_ready", if_a.in_ready, 1'b1);
    tick(40);
    chk("s3_no_done", done_qa.size(), 0);
    clear_a();
    w = {$urandom, $urandom};
    send(0, w, 1'b0, e0);
    tick(34);
    chk("s3_restart_n", byt_a.size(), 8);
    if (byt_a.size() > 0) chk("s3_restart_b0", byt_a[0], w[7:0]);

    // 4: reset and valid together.
    w = {$urandom, $urandom};
    rst_a = 1'b1;
    set_in(0, 1'b1, w);
    tick(1);
    chk("s4_no_strobe", strobe_a, 1'b0);
    chk("s4_no_busy", busy_a, 1'b0);
    chk("s4_bits", bits_a, 8'h00);
    rst_a = 1'b0;
    tick(1);
    chk("s4_strobe", strobe_a, 1'b1);
    chk("s4_b0", bits_a, w[7:0]);
    set_in(0, 1'b0, w);
    tick(34);

    // 5: default divider.
    str_b.delete(); byt_b.delete(); done_qb.delete();
    send(1, 64'hFF00FF00FF00FF00, 1'b0, e0);
    tick(8 * DIV_B + 4);
    chk("s5_nstrobe", str_b.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < str_b.size()) begin
        if (k > 0) chk("s5_spacing", str_b[k] - str_b[k-1], 3334);
        chk("s5_byte", byt_b[k], (k % 2 == 0) ? 8'h00 : 8'hFF);
      end
    end
    chk("s5_ndone", done_qb.size(), 1);
    if (done_qb.size() > 0) chk("s5_done_ofs", done_qb[0] - e0, 26672);

    // 6: loopback reassembly of random words.
    for (int n = 0; n < 10; n++) begin
      w = {$urandom, $urandom};
      exp_q.push_back(w);
      clear_a();
      send(0, w, 1'b0, e0);
      tick(33);
      rebuilt = 64'd0;
      for (int k = 0; k < 8; k++) begin
        if (k < byt_a.size()) rebuilt[8*k +: 8] = byt_a[k];
        if (k > 0 && k < str_a.size()) chk("s6_spacing", str_a[k] - str_a[k-1], 4);
      end
      chk("s6_nstrobe", str_a.size(), 8);
      chk("s6_word", rebuilt, exp_q.pop_front());
      tick($urandom_range(0, 3));
    end

    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
